// File: rtl/mcdt_pkt_formatter.sv
// mcdt_pkt_formatter: buffers the arbitrated mcdt word stream per channel and frames it into
// header + PKT_LEN payload packets; define MCDT_PKT_FORMATTER_CHKSUM_EN to append an XOR trailer.
module mcdt_pkt_formatter #(
    parameter int         DEPTH   = 16,
    parameter int         PKT_LEN = 4,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mcdt_data_i,
    input  logic        mcdt_val_i,
    input  logic [1:0]  mcdt_id_i,
    output logic [31:0] fmt_data_o,
    output logic        fmt_valid_o,
    input  logic        fmt_ready_i,
    output logic        fmt_first_o,
    output logic        fmt_last_o,
    output logic [2:0]  fmt_ovf_o
);
    localparam int            PW        = $clog2(DEPTH);
    localparam int            CW        = PW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] LEN       = CW'(PKT_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);
    localparam logic [7:0]    LEN_B     = 8'(PKT_LEN);

`ifdef MCDT_PKT_FORMATTER_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    logic [31:0]   mem    [3][DEPTH];
    logic [PW-1:0] wr_ptr [3];
    logic [PW-1:0] rd_ptr [3];
    logic [CW-1:0] count  [3];
    logic [7:0]    seq    [3];
    logic [2:0]    ovf;
    logic [1:0]    last_served;
    logic [1:0]    sel, sel_nxt;
    logic [CW-1:0] beat;
    state_t        state, state_nxt;
    logic [2:0]    full, wr_en, rd_en;
    logic          pop, hdr_done, pkt_done;
    logic          pick_any;
    logic [1:0]    pick;
    logic [31:0]   head;
`ifdef MCDT_PKT_FORMATTER_CHKSUM_EN
    logic [31:0]   chk_acc;
`endif

    function automatic logic [1:0] rr_chan(input logic [1:0] base, input int k);
        return 2'((int'(base) + k) % 3);
    endfunction

    assign head      = mem[sel][rd_ptr[sel]];
    assign fmt_ovf_o = ovf;

    // A full buffer refuses the write even if the same cycle pops it.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            full[c]  = (count[c] == FULL);
            wr_en[c] = mcdt_val_i && (mcdt_id_i == 2'(c)) && !full[c];
            rd_en[c] = pop && (sel == 2'(c));
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            if (wr_en[c]) begin
                mem[c][wr_ptr[c]] <= mcdt_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < 3; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
                seq[c]    <= '0;
            end
            ovf <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (wr_en[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PW'(1);
                end
                if (rd_en[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                end
                if (wr_en[c] && !rd_en[c]) begin
                    count[c] <= count[c] + CW'(1);
                end else if (!wr_en[c] && rd_en[c]) begin
                    count[c] <= count[c] - CW'(1);
                end
                if (mcdt_val_i && (mcdt_id_i == 2'(c)) && full[c]) begin
                    ovf[c] <= 1'b1;
                end
                if (pkt_done && (sel == 2'(c))) begin
                    seq[c] <= seq[c] + 8'd1;
                end
            end
        end
    end

    // Round robin: search starts at the channel after the one served last.
    always_comb begin
        pick_any = 1'b0;
        pick     = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            if (!pick_any && (count[rr_chan(last_served, k)] >= LEN)) begin
                pick_any = 1'b1;
                pick     = rr_chan(last_served, k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            sel         <= 2'd0;
            beat        <= '0;
            last_served <= 2'd2;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            if (hdr_done) begin
                beat <= '0;
            end else if (pop) begin
                beat <= beat + CW'(1);
            end
            if (pkt_done) begin
                last_served <= sel;
            end
        end
    end

`ifdef MCDT_PKT_FORMATTER_CHKSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || hdr_done) begin
            chk_acc <= '0;
        end else if (pop) begin
            chk_acc <= chk_acc ^ head;
        end
    end
`endif

    // Outputs come straight from the state and the buffer head, so they hold during a stall.
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        fmt_valid_o = 1'b0;
        fmt_first_o = 1'b0;
        fmt_last_o  = 1'b0;
        fmt_data_o  = '0;
        pop         = 1'b0;
        hdr_done    = 1'b0;
        pkt_done    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_nxt   = pick;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                fmt_valid_o = 1'b1;
                fmt_first_o = 1'b1;
                fmt_data_o  = {SYNC, sel, 6'b0, LEN_B, seq[sel]};
                if (fmt_ready_i) begin
                    hdr_done  = 1'b1;
                    state_nxt = PAY;
                end
            end
            PAY: begin
                fmt_valid_o = 1'b1;
                fmt_data_o  = head;
                pop         = fmt_ready_i;
                if (beat == LAST_BEAT) begin
`ifdef MCDT_PKT_FORMATTER_CHKSUM_EN
                    if (fmt_ready_i) begin
                        state_nxt = CHK;
                    end
`else
                    fmt_last_o = 1'b1;
                    if (fmt_ready_i) begin
                        pkt_done  = 1'b1;
                        state_nxt = IDLE;
                    end
`endif
                end
            end
`ifdef MCDT_PKT_FORMATTER_CHKSUM_EN
            CHK: begin
                fmt_valid_o = 1'b1;
                fmt_last_o  = 1'b1;
                fmt_data_o  = chk_acc;
                if (fmt_ready_i) begin
                    pkt_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mcdt_pkt_formatter.sv
// tb_mcdt_pkt_formatter: directed scenarios plus a randomized run checked against a
// queue-per-channel packet model of the formatter.
module tb_mcdt_pkt_formatter;
    localparam int DEPTH   = 16;
    localparam int PKT_LEN = 4;
`ifdef MCDT_PKT_FORMATTER_CHKSUM_EN
    localparam bit HAS_CHK = 1'b1;
`else
    localparam bit HAS_CHK = 1'b0;
`endif
    localparam int PKT_WORDS = PKT_LEN + 1 + int'(HAS_CHK);

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] mcdt_data_i;
    logic        mcdt_val_i;
    logic [1:0]  mcdt_id_i;
    logic [31:0] fmt_data_o;
    logic        fmt_valid_o;
    logic        fmt_ready_i;
    logic        fmt_first_o;
    logic        fmt_last_o;
    logic [2:0]  fmt_ovf_o;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_pay [0:PKT_LEN-1];
    logic [31:0] rx_w [0:7];
    logic        rx_f [0:7];
    logic        rx_l [0:7];
    int          rx_n;
    int          rx_unstable;
    bit          rx_ok;
    logic [31:0] mq [3][$];

    mcdt_pkt_formatter #(.DEPTH(DEPTH), .PKT_LEN(PKT_LEN), .SYNC(8'hA5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mcdt_data_i(mcdt_data_i), .mcdt_val_i(mcdt_val_i), .mcdt_id_i(mcdt_id_i),
        .fmt_data_o(fmt_data_o), .fmt_valid_o(fmt_valid_o), .fmt_ready_i(fmt_ready_i),
        .fmt_first_o(fmt_first_o), .fmt_last_o(fmt_last_o), .fmt_ovf_o(fmt_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] hdr(input int ch, input logic [7:0] s);
        logic [1:0] c2 = 2'(ch);
        return {8'hA5, c2, 6'b0, 8'(PKT_LEN), s};
    endfunction

    // Word k of a packet: header, payload from exp_pay, then the XOR trailer if present.
    function automatic logic [31:0] exp_word(input int k, input int ch, input logic [7:0] s);
        logic [31:0] x = '0;
        if (k == 0) return hdr(ch, s);
        if (k <= PKT_LEN) return exp_pay[k-1];
        for (int i = 0; i < PKT_LEN; i++) x ^= exp_pay[i];
        return x;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        mcdt_val_i = 1'b0;
        fmt_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic write_word(input logic [1:0] id, input logic [31:0] d);
        mcdt_val_i = 1'b1;
        mcdt_id_i = id;
        mcdt_data_i = d;
        tick();
        mcdt_val_i = 1'b0;
    endtask

    // Collects one packet; toggle selects the 1,0,0,1 ready pattern and tracks stall stability.
    task automatic recv_packet(input bit toggle);
        int cyc = 0;
        bit done = 1'b0;
        bit pstall = 1'b0;
        logic [31:0] pd = '0;
        logic pf = 1'b0, pl = 1'b0;
        rx_n = 0; rx_unstable = 0; rx_ok = 1'b0;
        while (!done && cyc < 300) begin
            fmt_ready_i = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (pstall && (fmt_valid_o !== 1'b1 || fmt_data_o !== pd || fmt_first_o !== pf || fmt_last_o !== pl))
                rx_unstable++;
            pstall = fmt_valid_o && !fmt_ready_i;
            pd = fmt_data_o; pf = fmt_first_o; pl = fmt_last_o;
            if (fmt_valid_o && fmt_ready_i) begin
                if (rx_n < 8) begin
                    rx_w[rx_n] = fmt_data_o; rx_f[rx_n] = fmt_first_o; rx_l[rx_n] = fmt_last_o;
                end
                rx_n++;
                if (fmt_last_o) begin
                    done = 1'b1;
                    rx_ok = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        fmt_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        fmt_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) write_word(2'd1, 32'(i + 7));
        rst_i = 1'b1;
        tick();
        vectors++;
        if (fmt_valid_o !== 1'b0 || fmt_first_o !== 1'b0 || fmt_last_o !== 1'b0)
            begin miscompares++; $display("[TB] FAIL reset_ctrl: got v%b f%b l%b, want 000", fmt_valid_o, fmt_first_o, fmt_last_o); end
        vectors++;
        if (fmt_data_o !== 32'h0)
            begin miscompares++; $display("[TB] FAIL reset_data: got %h, want 0", fmt_data_o); end
        vectors++;
        if (fmt_ovf_o !== 3'b000)
            begin miscompares++; $display("[TB] FAIL reset_ovf: got %b, want 000", fmt_ovf_o); end
        rst_i = 1'b0;
        tick();
        vectors++;
        if (fmt_valid_o !== 1'b0)
            begin miscompares++; $display("[TB] FAIL reset_flush: got valid %b, want 0", fmt_valid_o); end
    endtask

    task automatic test_basic();
        do_reset();
        fmt_ready_i = 1'b1;
        for (int i = 0; i < PKT_LEN; i++) begin
            exp_pay[i] = 32'(i + 1);
            write_word(2'd1, 32'(i + 1));
        end
        vectors++;
        if (fmt_valid_o !== 1'b0)
            begin miscompares++; $display("[TB] FAIL basic_select_gap: got valid %b, want 0", fmt_valid_o); end
        tick();
        for (int k = 0; k < PKT_WORDS; k++) begin
            vectors++;
            if (fmt_valid_o !== 1'b1 || fmt_data_o !== exp_word(k, 1, 8'd0) || fmt_first_o !== (k == 0) || fmt_last_o !== (k == PKT_WORDS - 1))
                begin miscompares++; $display("[TB] FAIL basic_word%0d: got v%b %h f%b l%b, want %h", k, fmt_valid_o, fmt_data_o, fmt_first_o, fmt_last_o, exp_word(k, 1, 8'd0)); end
            tick();
        end
        vectors++;
        if (fmt_valid_o !== 1'b0)
            begin miscompares++; $display("[TB] FAIL basic_end: got valid %b, want 0", fmt_valid_o); end
        fmt_ready_i = 1'b0;
    endtask

    task automatic test_round_robin();
        int ch;
        do_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < PKT_LEN; i++) write_word(2'(c), 32'h100 * c + i + 1);
        for (int p = 0; p < 5; p++) begin
            if (p == 3) begin
                for (int i = 0; i < PKT_LEN; i++) write_word(2'd0, 32'h1000 + i + 1);
                for (int i = 0; i < PKT_LEN; i++) write_word(2'd2, 32'h1200 + i + 1);
            end
            ch = (p == 0 || p == 3) ? 0 : (p == 1) ? 1 : 2;
            for (int i = 0; i < PKT_LEN; i++) exp_pay[i] = 32'h1000 * (p / 3) + 32'h100 * ch + i + 1;
            recv_packet(1'b0);
            vectors++;
            if (!rx_ok || rx_n != PKT_WORDS)
                begin miscompares++; $display("[TB] FAIL rr_len p%0d: got %0d words ok=%0d, want %0d", p, rx_n, rx_ok, PKT_WORDS); end
            for (int k = 0; k < PKT_WORDS; k++) begin
                vectors++;
                if (rx_w[k] !== exp_word(k, ch, 8'(p / 3)) || rx_f[k] !== (k == 0) || rx_l[k] !== (k == PKT_WORDS - 1))
                    begin miscompares++; $display("[TB] FAIL rr_word p%0d k%0d: got %h f%b l%b, want %h", p, k, rx_w[k], rx_f[k], rx_l[k], exp_word(k, ch, 8'(p / 3))); end
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int i = 0; i < PKT_LEN; i++) begin
            exp_pay[i] = $urandom;
            write_word(2'd2, exp_pay[i]);
        end
        recv_packet(1'b1);
        vectors++;
        if (!rx_ok || rx_n != PKT_WORDS || rx_unstable != 0)
            begin miscompares++; $display("[TB] FAIL bp_stream: got %0d words ok=%0d unstable=%0d, want %0d words stable", rx_n, rx_ok, rx_unstable, PKT_WORDS); end
        for (int k = 0; k < PKT_WORDS; k++) begin
            vectors++;
            if (rx_w[k] !== exp_word(k, 2, 8'd0) || rx_f[k] !== (k == 0) || rx_l[k] !== (k == PKT_WORDS - 1))
                begin miscompares++; $display("[TB] FAIL bp_word k%0d: got %h f%b l%b, want %h", k, rx_w[k], rx_f[k], rx_l[k], exp_word(k, 2, 8'd0)); end
        end
    endtask

    task automatic test_overflow();
        int spurious = 0;
        do_reset();
        for (int i = 1; i <= DEPTH; i++) write_word(2'd0, 32'(i));
        vectors++;
        if (fmt_ovf_o !== 3'b000)
            begin miscompares++; $display("[TB] FAIL ovf_before: got %b, want 000", fmt_ovf_o); end
        write_word(2'd0, 32'(DEPTH + 1));
        vectors++;
        if (fmt_ovf_o !== 3'b001)
            begin miscompares++; $display("[TB] FAIL ovf_set: got %b, want 001", fmt_ovf_o); end
        for (int p = 0; p < DEPTH / PKT_LEN; p++) begin
            for (int i = 0; i < PKT_LEN; i++) exp_pay[i] = 32'(p * PKT_LEN + i + 1);
            recv_packet(1'b0);
            for (int k = 0; k < PKT_WORDS; k++) begin
                vectors++;
                if (!rx_ok || rx_w[k] !== exp_word(k, 0, 8'(p)) || rx_l[k] !== (k == PKT_WORDS - 1))
                    begin miscompares++; $display("[TB] FAIL ovf_word p%0d k%0d: got %h l%b ok=%0d, want %h", p, k, rx_w[k], rx_l[k], rx_ok, exp_word(k, 0, 8'(p))); end
            end
        end
        fmt_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (fmt_valid_o) spurious++;
            tick();
        end
        fmt_ready_i = 1'b0;
        vectors++;
        if (spurious != 0 || fmt_ovf_o !== 3'b001)
            begin miscompares++; $display("[TB] FAIL ovf_drop: got %0d extra words ovf=%b, want 0 and 001", spurious, fmt_ovf_o); end
    endtask

    task automatic test_illegal_and_seq_wrap();
        int spurious = 0;
        do_reset();
        fmt_ready_i = 1'b1;
        for (int i = 0; i < 2 * PKT_LEN; i++) write_word(2'd3, $urandom);
        for (int i = 0; i < 10; i++) begin
            if (fmt_valid_o) spurious++;
            tick();
        end
        vectors++;
        if (spurious != 0 || fmt_ovf_o !== 3'b000)
            begin miscompares++; $display("[TB] FAIL illegal_id: got %0d words ovf=%b, want 0 and 000", spurious, fmt_ovf_o); end
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < PKT_LEN; i++) write_word(2'd0, 32'(p * PKT_LEN + i));
            recv_packet(1'b0);
            vectors++;
            if (!rx_ok || rx_w[0] !== hdr(0, 8'(p)))
                begin miscompares++; $display("[TB] FAIL seq_hdr p%0d: got %h ok=%0d, want %h", p, rx_w[0], rx_ok, hdr(0, 8'(p))); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int hs = 0, cyc = 0, spurious = 0;
        do_reset();
        for (int i = 0; i < PKT_LEN; i++) write_word(2'd1, $urandom);
        recv_packet(1'b0);
        vectors++;
        if (!rx_ok || rx_w[0] !== hdr(1, 8'd0))
            begin miscompares++; $display("[TB] FAIL rstmid_pre: got %h, want %h", rx_w[0], hdr(1, 8'd0)); end
        for (int i = 0; i <= DEPTH; i++) write_word(2'd2, 32'(i));
        vectors++;
        if (fmt_ovf_o !== 3'b100)
            begin miscompares++; $display("[TB] FAIL rstmid_ovf: got %b, want 100", fmt_ovf_o); end
        fmt_ready_i = 1'b1;
        while (hs < 3 && cyc < 50) begin
            if (fmt_valid_o && fmt_ready_i) hs++;
            tick();
            cyc++;
        end
        vectors++;
        if (hs != 3)
            begin miscompares++; $display("[TB] FAIL rstmid_timeout: got %0d handshakes, want 3", hs); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        vectors++;
        if (fmt_valid_o !== 1'b0 || fmt_ovf_o !== 3'b000)
            begin miscompares++; $display("[TB] FAIL rstmid_clear: got valid %b ovf %b, want 0 000", fmt_valid_o, fmt_ovf_o); end
        for (int i = 0; i < 10; i++) begin
            if (fmt_valid_o) spurious++;
            tick();
        end
        vectors++;
        if (spurious != 0)
            begin miscompares++; $display("[TB] FAIL rstmid_abandon: got %0d stale words, want 0", spurious); end
        for (int i = 0; i < PKT_LEN; i++) write_word(2'd1, $urandom);
        recv_packet(1'b0);
        vectors++;
        if (!rx_ok || rx_w[0] !== hdr(1, 8'd0))
            begin miscompares++; $display("[TB] FAIL rstmid_fresh: got %h, want %h", rx_w[0], hdr(1, 8'd0)); end
    endtask

    // Model: one FIFO queue per channel, sequence counters and round robin over queue occupancy.
    task automatic test_random();
        int cur_sz [3], prev_sz [3];
        logic [7:0] seq_m [3];
        int ls = 2, phase = 0, cur = 0, beat = 0, pick, eligible = 0;
        logic [2:0] ovf_m = '0;
        logic [31:0] acc = '0, exp_d, exp_h, pd = '0;
        logic pf = 1'b0, pl = 1'b0, pstall = 1'b0, done;
        logic v, r;
        logic [1:0] id;
        logic [31:0] d;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            mq[c].delete(); prev_sz[c] = 0; seq_m[c] = 8'd0;
        end
        for (int t = 0; t < 3500; t++) begin
            for (int c = 0; c < 3; c++) cur_sz[c] = mq[c].size();
            vectors++;
            if (fmt_ovf_o !== ovf_m)
                begin miscompares++; $display("[TB] FAIL rnd_ovf t%0d: got %b, want %b", t, fmt_ovf_o, ovf_m); end
            if (pstall) begin
                vectors++;
                if (fmt_valid_o !== 1'b1 || fmt_data_o !== pd || fmt_first_o !== pf || fmt_last_o !== pl)
                    begin miscompares++; $display("[TB] FAIL rnd_hold t%0d: got v%b %h f%b l%b, want held %h", t, fmt_valid_o, fmt_data_o, fmt_first_o, fmt_last_o, pd); end
            end
            if (fmt_valid_o && phase == 0) begin
                pick = -1;
                for (int k = 1; k <= 3; k++)
                    if (pick < 0 && prev_sz[(ls + k) % 3] >= PKT_LEN) pick = (ls + k) % 3;
                cur = (pick < 0) ? 0 : pick;
                exp_h = hdr(cur, seq_m[cur]);
                vectors++;
                if (pick < 0 || fmt_first_o !== 1'b1 || fmt_data_o !== exp_h)
                    begin miscompares++; $display("[TB] FAIL rnd_hdr t%0d: got %h f%b, want %h (pick %0d)", t, fmt_data_o, fmt_first_o, exp_h, pick); end
                phase = 1;
            end
            if (t < 3200) begin
                v = ($urandom_range(0, 99) < 60);
                id = 2'($urandom_range(0, 3));
                d = $urandom;
                r = ($urandom_range(0, 99) < ((t < 1600) ? 25 : 75));
            end else begin
                v = 1'b0; id = 2'd0; d = '0; r = 1'b1;
            end
            mcdt_val_i = v; mcdt_id_i = id; mcdt_data_i = d; fmt_ready_i = r;
            if (fmt_valid_o && r) begin
                done = 1'b0;
                if (phase == 1) begin
                    phase = 2; beat = 0; acc = '0;
                end else if (phase == 2) begin
                    exp_d = (mq[cur].size() > 0) ? mq[cur].pop_front() : 32'hDEAD_0000;
                    vectors++;
                    if (fmt_data_o !== exp_d || fmt_first_o !== 1'b0 || fmt_last_o !== (!HAS_CHK && beat == PKT_LEN - 1))
                        begin miscompares++; $display("[TB] FAIL rnd_pay t%0d beat%0d: got %h f%b l%b, want %h", t, beat, fmt_data_o, fmt_first_o, fmt_last_o, exp_d); end
                    acc ^= exp_d;
                    beat++;
                    if (beat == PKT_LEN) begin
                        phase = HAS_CHK ? 3 : 0;
                        done = !HAS_CHK;
                    end
                end else if (phase == 3) begin
                    vectors++;
                    if (fmt_data_o !== acc || fmt_last_o !== 1'b1 || fmt_first_o !== 1'b0)
                        begin miscompares++; $display("[TB] FAIL rnd_chk t%0d: got %h l%b, want %h", t, fmt_data_o, fmt_last_o, acc); end
                    phase = 0;
                    done = 1'b1;
                end
                if (done) begin
                    seq_m[cur] = seq_m[cur] + 8'd1;
                    ls = cur;
                end
            end
            if (v && id != 2'd3) begin
                if (cur_sz[id] < DEPTH) mq[id].push_back(d);
                else ovf_m[id] = 1'b1;
            end
            pstall = fmt_valid_o && !r;
            pd = fmt_data_o; pf = fmt_first_o; pl = fmt_last_o;
            prev_sz = cur_sz;
            tick();
        end
        mcdt_val_i = 1'b0;
        fmt_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) if (mq[c].size() >= PKT_LEN) eligible++;
        vectors++;
        if (eligible != 0 || phase != 0)
            begin miscompares++; $display("[TB] FAIL rnd_drain: got %0d full channels phase %0d, want 0 0", eligible, phase); end
    endtask

    initial begin
        rst_i = 1'b1;
        mcdt_val_i = 1'b0;
        mcdt_id_i = 2'd0;
        mcdt_data_i = '0;
        fmt_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_back_pressure();
        test_overflow();
        test_illegal_and_seq_wrap();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
